glm_c1_write_arbiter: RTL and testbench
=======================================

// Module: glm_c1_write_arbiter
// PURPOSE
// - Shares one CCI-P c1 (write) channel among NUM_REQ writeback engines (glm writeback, checkpoint, stats).
// - Buffers each requester's writes, grants the channel round-robin and tags mdata with the requester ID.
// - Routes write/fence acks back to the issuing requester and keeps a per-requester outstanding count.
// - Sits between the engines and the AFU top-level c1 ports.
// PARAMETERS
// - NUM_REQ     4  number of requesters, 2..16
// - FIFO_DEPTH  8  per-requester request buffer entries; power of 2, >=8
// - ALMFULL_TH  4  free entries at or below which req_almfull[i] asserts
// PORTS
// - clk              in   1              clock
// - reset            in   1              synchronous, active-low (0 = reset)
// - req_c1[NUM_REQ]  in   t_if_ccip_c1_Tx per-requester write req (valid, hdr, 512b data)
// - req_almfull      out  NUM_REQ        per-requester back-pressure
// - rsp_c1[NUM_REQ]  out  t_if_ccip_c1_Rx per-requester ack (rspValid, hdr with restored mdata)
// - req_idle         out  NUM_REQ        FIFO empty and outstanding==0
// - err_overflow     out  NUM_REQ        sticky: push into full FIFO
// - c1TxAlmFull      in   1              CCI-P c1 almost-full
// - cp2af_sRx_c1     in   t_if_ccip_c1_Rx CCI-P c1 responses
// - af2cp_sTx_c1     out  t_if_ccip_c1_Tx CCI-P c1 requests (registered)
// BEHAVIOUR
// - Reset (reset==0, sampled at posedge): FIFOs flushed, rr pointer=0, counters=0, err_overflow=0,
//   af2cp_sTx_c1.valid=0, rsp_c1[*].rspValid=0, req_almfull=0, req_idle=all 1.
//   Reset mid-burst drops buffered and in-flight bookkeeping; acks arriving after reset are ignored.
// - Push: req_c1[i].valid pushes {hdr,data} the same cycle. Full FIFO: entry dropped, err_overflow[i]<=1.
// - req_almfull[i] is registered: 1 when free entries <= ALMFULL_TH. Engines keep <= ALMFULL_TH-1 beats in flight after it rises.
// - Arbitration, per cycle:
//   - Eligible when c1TxAlmFull==0 and at least one FIFO is non-empty.
//   - Grant the first non-empty index at or after rr_ptr (wrapping), then rr_ptr <= grant+1 mod NUM_REQ.
//   - Stay one request per cycle. Latency: FIFO head -> af2cp valid = 1 cycle, so an empty-FIFO push reaches CCI-P 2 cycles later.
//   - c1TxAlmFull==1: no pop, af2cp valid=0 next cycle; FIFO contents held.
// - Tagging: issued hdr.mdata[15:12] <= grant ID; mdata[11:0] and all other hdr fields pass unchanged.
//   Engines keep mdata[15:12]=0. Single-line writes only (cl_len=0). WRFENCE req_type passes as-is.
// - Outstanding[i] (16b): +1 on issue of i, -1 on ack for i; both in one cycle -> unchanged. No wrap is legal (<=65535).
// - Ack routing: cp2af_sRx_c1.rspValid with mdata[15:12]=k<NUM_REQ -> rsp_c1[k].rspValid=1 next cycle.
//   Hdr forwarded with mdata[15:12] cleared. k>=NUM_REQ is dropped.
//   Counts as one ack: format/cl_num are ignored.
// - req_idle[i] is registered from (FIFO empty && outstanding==0 && not issuing i this cycle).
//   Engines use it to decide when to raise op_done with write_fence.
// - Simultaneous push to empty FIFO and arbitration: the entry is not visible until the next cycle; there is no bypass.
// STRUCTURE
// - Shared package, pipearch_common.vh:
//   - t_c1_req_entry struct {t_cci_c1_ReqMemHdr hdr; logic [511:0] data;}
//   - localparams C1_RID_LSB=12, C1_RID_W=4.
// - Sub-module c1_req_fifo: synchronous FIFO of t_c1_req_entry with count output, FIFO_DEPTH entries.
//   Generate one per requester.
// - Top: rr arbiter (combinational pick + registered pointer), output register, ack demux, counters.
// TESTING
// - Single req0, 4 writes mdata=0x001..0x004: af2cp mdata 0x001..0x004, one per cycle, and rsp_c1[0] gets 4 acks.
//   req_idle[0] returns to 1.
// - All 4 requesters push 3 each in the same cycle: issue order 0,1,2,3,0,1,2,3,0,1,2,3.
//   mdata[15:12] matches the ID.
// - Hold c1TxAlmFull=1 for 10 cycles while req1 pushes 5: valid stays 0, req_almfull[1]=1 at 4 queued.
//   All 5 issue after release, in order.
// - Push 9 into req2 with c1TxAlmFull=1: err_overflow[2]=1, 8 entries issued, 9th lost.
// - Ack with mdata[15:12]=3 and an issue for req3 in the same cycle: outstanding[3] unchanged.
//   Ack with mdata[15:12]=7 (NUM_REQ=4) is dropped.
// - Assert reset=0 with 3 queued and 2 outstanding: next cycle all outputs at reset values.
//   A late ack is ignored and no rspValid is produced.

Source files
------------

// File: rtl/glm_c1_write_arbiter_pkg.sv
// Shared types for the glm c1 (write) channel arbiter.
// Purpose: CCI-P c1 request/response structures as seen by this block, the
// buffered request entry, the requester-ID field position inside mdata and a
// helper that overwrites that field.
package glm_c1_write_arbiter_pkg;

  localparam int C1_RID_LSB = 12;
  localparam int C1_RID_W   = 4;

  localparam logic [3:0] eREQ_WRLINE_I = 4'h0;
  localparam logic [3:0] eREQ_WRLINE_M = 4'h1;
  localparam logic [3:0] eREQ_WRFENCE  = 4'h4;

  typedef struct packed {
    logic [1:0]  vc_sel;
    logic        sop;
    logic [1:0]  cl_len;
    logic [3:0]  req_type;
    logic [41:0] address;
    logic [15:0] mdata;
  } t_cci_c1_ReqMemHdr;

  typedef struct packed {
    logic [1:0]  vc_used;
    logic        hit_miss;
    logic        format;
    logic [1:0]  cl_num;
    logic [3:0]  resp_type;
    logic [15:0] mdata;
  } t_cci_c1_RspMemHdr;

  typedef struct packed {
    t_cci_c1_ReqMemHdr hdr;
    logic [511:0]      data;
    logic              valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_cci_c1_RspMemHdr hdr;
    logic              rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    t_cci_c1_ReqMemHdr hdr;
    logic [511:0]      data;
  } t_c1_req_entry;

  function automatic logic [15:0] c1_set_rid(input logic [15:0]         mdata,
                                             input logic [C1_RID_W-1:0] rid);
    logic [15:0] m;
    m = mdata;
    m[C1_RID_LSB +: C1_RID_W] = rid;
    return m;
  endfunction

endpackage

// File: rtl/glm_c1_write_arbiter_fifo.sv
// c1_req_fifo: synchronous FIFO of c1 write request entries.
// Ports:
//   clk, reset    clock, synchronous active-low reset (flushes pointers/count)
//   push_i        write entry_i; ignored when full
//   entry_i       {hdr, data} to buffer
//   pop_i         drop the head entry; ignored when empty
//   head_o        current head entry (combinational read)
//   empty_o/full_o occupancy flags
//   count_o       number of entries held
module c1_req_fifo
  import glm_c1_write_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push_i,
  input  t_c1_req_entry                   entry_i,
  input  logic                            pop_i,
  output t_c1_req_entry                   head_o,
  output logic                            empty_o,
  output logic                            full_o,
  output logic [$clog2(FIFO_DEPTH):0]     count_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  t_c1_req_entry mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/glm_c1_write_arbiter.sv
// glm_c1_write_arbiter: shares one CCI-P c1 write channel among NUM_REQ engines.
// Each requester's writes are buffered, granted round-robin, tagged with the
// requester ID in mdata[15:12], and acks are routed back with the tag cleared.
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   req_c1[NUM_REQ]   per-requester write requests
//   req_almfull       per-requester back-pressure (registered)
//   rsp_c1[NUM_REQ]   per-requester acks, mdata tag cleared
//   req_idle          FIFO empty and nothing outstanding (registered)
//   err_overflow      sticky: a push hit a full FIFO
//   c1TxAlmFull       CCI-P c1 almost-full, stalls issue
//   cp2af_sRx_c1      CCI-P c1 responses
//   af2cp_sTx_c1      CCI-P c1 requests (registered)
module glm_c1_write_arbiter
  import glm_c1_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ALMFULL_TH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  t_if_ccip_c1_Tx      req_c1 [NUM_REQ],
  output logic [NUM_REQ-1:0]  req_almfull,
  output t_if_ccip_c1_Rx      rsp_c1 [NUM_REQ],
  output logic [NUM_REQ-1:0]  req_idle,
  output logic [NUM_REQ-1:0]  err_overflow,
  input  logic                c1TxAlmFull,
  input  t_if_ccip_c1_Rx      cp2af_sRx_c1,
  output t_if_ccip_c1_Tx      af2cp_sTx_c1
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] TH_C    = CW'(ALMFULL_TH);

  t_c1_req_entry      push_ent [NUM_REQ];
  t_c1_req_entry      head     [NUM_REQ];
  logic [CW-1:0]      count    [NUM_REQ];
  logic [NUM_REQ-1:0] empty, full, pop, ack_hit;

  logic [PW-1:0]      rr_ptr_q, rr_ptr_d, gnt_id;
  logic               gnt_vld, issue;
  logic [C1_RID_W-1:0] ack_rid;

  logic               tx_vld_q;
  t_cci_c1_ReqMemHdr  tx_hdr_q, tx_hdr_d;
  logic [511:0]       tx_data_q;
  logic [NUM_REQ-1:0] rsp_vld_q;
  t_cci_c1_RspMemHdr  rsp_hdr_q, rsp_hdr_d;
  logic [15:0]        outst_q [NUM_REQ];
  logic [NUM_REQ-1:0] almfull_q, idle_q, err_q;

  assign ack_rid = cp2af_sRx_c1.hdr.mdata[C1_RID_LSB +: C1_RID_W];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign push_ent[i] = {req_c1[i].hdr, req_c1[i].data};

    c1_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (req_c1[i].valid),
      .entry_i (push_ent[i]),
      .pop_i   (pop[i]),
      .head_o  (head[i]),
      .empty_o (empty[i]),
      .full_o  (full[i]),
      .count_o (count[i])
    );

    assign pop[i] = issue && (gnt_id == PW'(i));
    // An ack for a requester with nothing outstanding predates a reset; drop it.
    assign ack_hit[i] = cp2af_sRx_c1.rspValid && (ack_rid == C1_RID_W'(i)) &&
                        (outst_q[i] != 16'd0);
    assign rsp_c1[i] = {rsp_hdr_q, rsp_vld_q[i]};
  end

  // Rotating priority: the lowest offset from rr_ptr wins, so scan offsets
  // from the highest down and let the last hit stand.
  always_comb begin
    logic [PW:0] sum;
    logic [PW-1:0] idx;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    sum     = '0;
    idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_REQ)) sum = sum - (PW+1)'(NUM_REQ);
      idx = sum[PW-1:0];
      if (!empty[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
    issue    = gnt_vld && !c1TxAlmFull;
    rr_ptr_d = (gnt_id == PW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

    tx_hdr_d       = head[gnt_id].hdr;
    tx_hdr_d.mdata = c1_set_rid(tx_hdr_d.mdata, C1_RID_W'(gnt_id));
    rsp_hdr_d       = cp2af_sRx_c1.hdr;
    rsp_hdr_d.mdata = c1_set_rid(rsp_hdr_d.mdata, '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_q  <= '0;
      tx_vld_q  <= 1'b0;
      rsp_vld_q <= '0;
      almfull_q <= '0;
      idle_q    <= '1;
      err_q     <= '0;
      for (int i = 0; i < NUM_REQ; i++) outst_q[i] <= '0;
    end else begin
      if (issue) rr_ptr_q <= rr_ptr_d;
      tx_vld_q  <= issue;
      rsp_vld_q <= ack_hit;
      for (int i = 0; i < NUM_REQ; i++) begin
        almfull_q[i] <= (DEPTH_C - count[i]) <= TH_C;
        idle_q[i]    <= empty[i] && (outst_q[i] == 16'd0) && !pop[i];
        err_q[i]     <= err_q[i] | (req_c1[i].valid & full[i]);
        if (pop[i] && !ack_hit[i])      outst_q[i] <= outst_q[i] + 16'd1;
        else if (ack_hit[i] && !pop[i]) outst_q[i] <= outst_q[i] - 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      tx_hdr_q  <= tx_hdr_d;
      tx_data_q <= head[gnt_id].data;
    end
    rsp_hdr_q <= rsp_hdr_d;
  end

  assign af2cp_sTx_c1 = {tx_hdr_q, tx_data_q, tx_vld_q};
  assign req_almfull  = almfull_q;
  assign req_idle     = idle_q;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_glm_c1_write_arbiter.sv
// Bench for glm_c1_write_arbiter: directed scenarios plus a randomized phase,
// all checked cycle by cycle against a queue-based reference model.
module tb_glm_c1_write_arbiter;
  import glm_c1_write_arbiter_pkg::*;

  localparam int NUM_REQ    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int ALMFULL_TH = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               c1TxAlmFull = 1'b0;
  t_if_ccip_c1_Tx     req_c1 [NUM_REQ];
  t_if_ccip_c1_Rx     rsp_c1 [NUM_REQ];
  logic [NUM_REQ-1:0] req_almfull, req_idle, err_overflow;
  t_if_ccip_c1_Rx     cp2af_sRx_c1;
  t_if_ccip_c1_Tx     af2cp_sTx_c1;

  always #5 clk = ~clk;

  glm_c1_write_arbiter #(
    .NUM_REQ(NUM_REQ), .FIFO_DEPTH(FIFO_DEPTH), .ALMFULL_TH(ALMFULL_TH)
  ) dut (
    .clk(clk), .reset(reset), .req_c1(req_c1), .req_almfull(req_almfull),
    .rsp_c1(rsp_c1), .req_idle(req_idle), .err_overflow(err_overflow),
    .c1TxAlmFull(c1TxAlmFull), .cp2af_sRx_c1(cp2af_sRx_c1),
    .af2cp_sTx_c1(af2cp_sTx_c1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: per-requester queues, outstanding counts, rr pointer.
  t_c1_req_entry      mq [NUM_REQ][$];
  int                 m_out [NUM_REQ];
  int                 m_rr = 0;
  logic [NUM_REQ-1:0] m_err = '0;
  logic [15:0]        pend [$];
  logic               e_vld = 1'b0;
  t_cci_c1_ReqMemHdr  e_hdr;
  logic [511:0]       e_data;
  logic [NUM_REQ-1:0] e_rsp = '0, e_alm = '0, e_idle = '1;
  t_cci_c1_RspMemHdr  e_rsp_hdr;

  task automatic model_cycle();
    int sz [NUM_REQ];
    int g, j, k;
    t_c1_req_entry ent;
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        mq[i].delete();
        m_out[i] = 0;
      end
      pend.delete();
      m_rr = 0; m_err = '0; e_vld = 1'b0; e_rsp = '0; e_alm = '0; e_idle = '1;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) sz[i] = mq[i].size();
      g = -1;
      if (!c1TxAlmFull)
        for (int n = 0; n < NUM_REQ; n++) begin
          j = (m_rr + n) % NUM_REQ;
          if (g < 0 && sz[j] > 0) g = j;
        end
      for (int i = 0; i < NUM_REQ; i++) begin
        e_idle[i] = (sz[i] == 0) && (m_out[i] == 0) && (g != i);
        e_alm[i]  = (FIFO_DEPTH - sz[i]) <= ALMFULL_TH;
      end
      e_rsp = '0;
      if (cp2af_sRx_c1.rspValid) begin
        k = int'(cp2af_sRx_c1.hdr.mdata[15:12]);
        if (k < NUM_REQ && m_out[k] > 0) begin
          e_rsp[k] = 1'b1;
          e_rsp_hdr = cp2af_sRx_c1.hdr;
          e_rsp_hdr.mdata[15:12] = 4'h0;
          m_out[k]--;
        end
      end
      e_vld = (g >= 0);
      if (g >= 0) begin
        ent = mq[g].pop_front();
        e_hdr = ent.hdr;
        e_hdr.mdata[15:12] = 4'(g);
        e_data = ent.data;
        m_out[g]++;
        m_rr = (g + 1) % NUM_REQ;
        pend.push_back(e_hdr.mdata);
      end
      for (int i = 0; i < NUM_REQ; i++)
        if (req_c1[i].valid) begin
          if (sz[i] >= FIFO_DEPTH) m_err[i] = 1'b1;
          else mq[i].push_back({req_c1[i].hdr, req_c1[i].data});
        end
    end
  endtask

  task automatic compare();
    chk_eq("tx_valid", af2cp_sTx_c1.valid, e_vld);
    if (e_vld) begin
      chk_eq("tx_hdr", af2cp_sTx_c1.hdr, e_hdr);
      chk_eq("tx_data", af2cp_sTx_c1.data, e_data);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      chk_eq($sformatf("rsp_valid%0d", i), rsp_c1[i].rspValid, e_rsp[i]);
      if (e_rsp[i]) chk_eq($sformatf("rsp_hdr%0d", i), rsp_c1[i].hdr, e_rsp_hdr);
    end
    chk_eq("req_almfull", req_almfull, e_alm);
    chk_eq("req_idle", req_idle, e_idle);
    chk_eq("err_overflow", err_overflow, m_err);
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    compare();
    for (int i = 0; i < NUM_REQ; i++) req_c1[i].valid = 1'b0;
    cp2af_sRx_c1.rspValid = 1'b0;
  endtask

  task automatic push_req(input int i, input logic [11:0] md);
    logic [511:0] d;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
    req_c1[i].valid        = 1'b1;
    req_c1[i].data         = d;
    req_c1[i].hdr.vc_sel   = 2'($urandom_range(0, 3));
    req_c1[i].hdr.sop      = 1'b1;
    req_c1[i].hdr.cl_len   = 2'b00;
    case ($urandom_range(0, 2))
      0:       req_c1[i].hdr.req_type = eREQ_WRLINE_I;
      1:       req_c1[i].hdr.req_type = eREQ_WRLINE_M;
      default: req_c1[i].hdr.req_type = eREQ_WRFENCE;
    endcase
    req_c1[i].hdr.address  = {10'($urandom), $urandom};
    req_c1[i].hdr.mdata    = {4'h0, md};
  endtask

  task automatic send_ack(input logic [15:0] md);
    cp2af_sRx_c1.rspValid      = 1'b1;
    cp2af_sRx_c1.hdr.mdata     = md;
    cp2af_sRx_c1.hdr.format    = 1'($urandom);
    cp2af_sRx_c1.hdr.cl_num    = 2'($urandom);
    cp2af_sRx_c1.hdr.resp_type = 4'($urandom);
    cp2af_sRx_c1.hdr.vc_used   = 2'($urandom);
    cp2af_sRx_c1.hdr.hit_miss  = 1'($urandom);
  endtask

  task automatic ack_rand();
    int p;
    logic [15:0] md;
    p  = $urandom_range(0, pend.size() - 1);
    md = pend[p];
    pend.delete(p);
    send_ack(md);
  endtask

  task automatic drain_all();
    for (int c = 0; c < 200; c++) begin
      if (pend.size() > 0) ack_rand();
      step();
    end
  endtask

  initial begin
    logic [15:0] old_tag;
    int p3;
    for (int i = 0; i < NUM_REQ; i++) req_c1[i] = '0;
    cp2af_sRx_c1 = '0;

    // reset state
    reset = 1'b0;
    step(); step();
    chk_eq("rst_idle", req_idle, {NUM_REQ{1'b1}});
    reset = 1'b1;
    step();

    // single requester, four writes, acks in order
    for (int m = 1; m <= 4; m++) begin
      push_req(0, 12'(m));
      step();
    end
    step(); step();
    for (int m = 0; m < 4; m++) begin
      send_ack(pend.pop_front());
      step();
    end
    step();
    chk_eq("idle0_after_acks", req_idle[0], 1'b1);

    // all requesters push three each in the same cycles
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NUM_REQ; i++) push_req(i, 12'($urandom));
      step();
    end
    repeat (14) step();
    drain_all();

    // channel stalled while requester 1 queues five
    c1TxAlmFull = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 5) push_req(1, 12'($urandom));
      step();
    end
    chk_eq("almfull1_stalled", req_almfull[1], 1'b1);
    c1TxAlmFull = 1'b0;
    repeat (8) step();
    drain_all();

    // overflow of requester 2
    c1TxAlmFull = 1'b1;
    for (int c = 0; c < 9; c++) begin
      push_req(2, 12'($urandom));
      step();
    end
    step();
    chk_eq("err2_overflow", err_overflow[2], 1'b1);
    c1TxAlmFull = 1'b0;
    repeat (12) step();
    drain_all();

    // ack and issue for requester 3 in the same cycle; out-of-range ack
    push_req(3, 12'h0a1);
    step(); step();
    push_req(3, 12'h0a2);
    step();
    p3 = -1;
    for (int q = 0; q < pend.size(); q++) if (p3 < 0 && pend[q][15:12] == 4'd3) p3 = q;
    if (p3 >= 0) begin
      send_ack(pend[p3]);
      pend.delete(p3);
    end
    step();
    chk_eq("outst3_same_cycle", dut.outst_q[3], 16'(m_out[3]));
    send_ack(16'h7abc);
    step();
    drain_all();

    // reset with queued and outstanding work, then a late ack
    push_req(1, 12'h011); step();
    push_req(1, 12'h012); step();
    step(); step();
    old_tag = pend[0];
    c1TxAlmFull = 1'b1;
    for (int c = 0; c < 3; c++) begin
      push_req(0, 12'($urandom));
      step();
    end
    reset = 1'b0;
    step();
    chk_eq("rst_mid_valid", af2cp_sTx_c1.valid, 1'b0);
    send_ack(old_tag);
    step();
    reset = 1'b1;
    c1TxAlmFull = 1'b0;
    send_ack(old_tag);
    step();
    step();
    chk_eq("late_ack_rsp1", rsp_c1[1].rspValid, 1'b0);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      c1TxAlmFull = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NUM_REQ; i++)
        if (req_almfull[i] ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0))
          push_req(i, 12'($urandom));
      if (pend.size() > 0 && $urandom_range(0, 2) == 0) ack_rand();
      else if ($urandom_range(0, 63) == 0) send_ack({4'($urandom_range(NUM_REQ, 15)), 12'($urandom)});
      step();
    end
    c1TxAlmFull = 1'b0;
    drain_all();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
